// File: rtl/logic_arbiter_if.sv
// Request/grant/result bundle between two requesters and the shared logic unit.
// The arbiter uses the slave modport; requesters (or a bench) use master.
interface logic_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic [1:0]       op0;
  logic [1:0]       op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic [7:0]       op_count;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1,
    output gnt0, gnt1, done0, done1, result, busy, op_count
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1,
    input  gnt0, gnt1, done0, done1, result, busy, op_count
  );
endinterface

// File: rtl/logic_arbiter.sv
// Round-robin arbiter sharing one AND/OR/XOR/NOT unit between two requesters.
// Each operation walks IDLE -> EXEC -> DONE; every output is a register.
module logic_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  logic_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic             r_last, w_last_next;
  logic [1:0]       r_op, w_op_next;
  logic [WIDTH-1:0] r_a, w_a_next;
  logic [WIDTH-1:0] r_b, w_b_next;
  logic [WIDTH-1:0] r_result, w_result_next;
  logic [7:0]       r_count, w_count_next;
  logic             r_gnt0, w_gnt0_next;
  logic             r_gnt1, w_gnt1_next;
  logic             r_done0, w_done0_next;
  logic             r_done1, w_done1_next;
  logic             r_busy, w_busy_next;
  logic             w_pick1;
  logic [WIDTH-1:0] w_fn;

  always_comb begin
    case (r_op)
      2'b00:   w_fn = r_a & r_b;
      2'b01:   w_fn = r_a | r_b;
      2'b10:   w_fn = r_a ^ r_b;
      default: w_fn = ~r_a;
    endcase
  end

  always_comb begin
    w_state_next  = r_state;
    w_last_next   = r_last;
    w_op_next     = r_op;
    w_a_next      = r_a;
    w_b_next      = r_b;
    w_result_next = r_result;
    w_count_next  = r_count;
    w_gnt0_next   = 1'b0;
    w_gnt1_next   = 1'b0;
    w_done0_next  = 1'b0;
    w_done1_next  = 1'b0;
    w_pick1       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req0 | bus.req1) begin
          // On a tie the requester that did not win last time goes first.
          w_pick1      = bus.req1 & (~bus.req0 | ~r_last);
          w_last_next  = w_pick1;
          w_op_next    = w_pick1 ? bus.op1 : bus.op0;
          w_a_next     = w_pick1 ? bus.a1 : bus.a0;
          w_b_next     = w_pick1 ? bus.b1 : bus.b0;
          w_gnt0_next  = ~w_pick1;
          w_gnt1_next  = w_pick1;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_result_next = w_fn;
        w_done0_next  = ~r_last;
        w_done1_next  = r_last;
        w_count_next  = r_count + 8'd1;
        w_state_next  = S_DONE;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= 1'b1;
      r_op     <= 2'b00;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_count  <= 8'd0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_last   <= w_last_next;
      r_op     <= w_op_next;
      r_a      <= w_a_next;
      r_b      <= w_b_next;
      r_result <= w_result_next;
      r_count  <= w_count_next;
      r_gnt0   <= w_gnt0_next;
      r_gnt1   <= w_gnt1_next;
      r_done0  <= w_done0_next;
      r_done1  <= w_done1_next;
      r_busy   <= w_busy_next;
    end
  end

  assign bus.gnt0     = r_gnt0;
  assign bus.gnt1     = r_gnt1;
  assign bus.done0    = r_done0;
  assign bus.done1    = r_done1;
  assign bus.result   = r_result;
  assign bus.busy     = r_busy;
  assign bus.op_count = r_count;
endmodule

// File: tb/tb_logic_arbiter.sv
// Self-checking bench for logic_arbiter: directed table, hand-written reset
// sequences, and random traffic checked against a transaction-level model.
module tb_logic_arbiter;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic_arbiter_if #(.WIDTH(W)) bus ();
  logic_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: who won last, and how many operations have completed.
  logic       m_last = 1'b1;
  logic [7:0] m_count = 8'd0;

  typedef struct {
    logic             r0, r1;
    logic [1:0]       op0, op1;
    logic [W-1:0]     a0, b0, a1, b1;
    int               win;
    logic [W-1:0]     res;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  function automatic int model_win(input logic r0, input logic r1);
    if (!r0 && !r1) return -1;
    if (r0 && r1) return m_last ? 0 : 1;
    return r0 ? 0 : 1;
  endfunction

  // Called at a negedge with the DUT in IDLE and requests already driven.
  task automatic run_round(input string name, input int exp_win, input logic [W-1:0] exp_res);
    logic [7:0] cnt_after;
    @(negedge clk);
    if (exp_win < 0) begin
      chk({name, ".gnt0"}, {31'd0, bus.gnt0}, 0);
      chk({name, ".gnt1"}, {31'd0, bus.gnt1}, 0);
      chk({name, ".busy"}, {31'd0, bus.busy}, 0);
      $display("op %s: no request, count=%0d", name, bus.op_count);
      return;
    end
    chk({name, ".gnt0"}, {31'd0, bus.gnt0}, (exp_win == 0) ? 1 : 0);
    chk({name, ".gnt1"}, {31'd0, bus.gnt1}, (exp_win == 1) ? 1 : 0);
    chk({name, ".busy_exec"}, {31'd0, bus.busy}, 1);
    chk({name, ".done_early"}, {30'd0, bus.done1, bus.done0}, 0);
    // Winner drops its request and scrambles operands; capture must be unaffected.
    if (exp_win == 0) begin
      bus.req0 = 1'b0; bus.op0 = 2'($urandom); bus.a0 = W'($urandom); bus.b0 = W'($urandom);
    end else begin
      bus.req1 = 1'b0; bus.op1 = 2'($urandom); bus.a1 = W'($urandom); bus.b1 = W'($urandom);
    end
    @(negedge clk);
    cnt_after = m_count + 8'd1;
    chk({name, ".done0"}, {31'd0, bus.done0}, (exp_win == 0) ? 1 : 0);
    chk({name, ".done1"}, {31'd0, bus.done1}, (exp_win == 1) ? 1 : 0);
    chk({name, ".gnt_clear"}, {30'd0, bus.gnt1, bus.gnt0}, 0);
    chk({name, ".result"}, {28'd0, bus.result}, {28'd0, exp_res});
    chk({name, ".op_count"}, {24'd0, bus.op_count}, {24'd0, cnt_after});
    chk({name, ".busy_done"}, {31'd0, bus.busy}, 1);
    m_count = cnt_after;
    m_last  = (exp_win == 1);
    @(negedge clk);
    chk({name, ".done_clear"}, {30'd0, bus.done1, bus.done0}, 0);
    chk({name, ".busy_idle"}, {31'd0, bus.busy}, 0);
    chk({name, ".result_hold"}, {28'd0, bus.result}, {28'd0, exp_res});
    $display("op %s: win=%0d result=%b count=%0d", name, exp_win, bus.result, bus.op_count);
  endtask

  initial begin
    int w;
    logic [W-1:0] er;

    tbl[0] = '{1, 0, 2'b01, 2'b00, 4'b1001, 4'b0101, 4'b0000, 4'b0000, 0, 4'b1101};
    tbl[1] = '{0, 1, 2'b00, 2'b01, 4'b0000, 4'b0000, 4'b0011, 4'b1100, 1, 4'b1111};
    tbl[2] = '{1, 1, 2'b00, 2'b10, 4'b1100, 4'b1010, 4'b1100, 4'b1010, 0, 4'b1000};
    tbl[3] = '{0, 1, 2'b00, 2'b10, 4'b1100, 4'b1010, 4'b1100, 4'b1010, 1, 4'b0110};
    tbl[4] = '{1, 1, 2'b00, 2'b10, 4'b1100, 4'b1010, 4'b1100, 4'b1010, 0, 4'b1000};
    tbl[5] = '{0, 1, 2'b00, 2'b10, 4'b1100, 4'b1010, 4'b1100, 4'b1010, 1, 4'b0110};
    tbl[6] = '{1, 0, 2'b11, 2'b00, 4'b0101, 4'b1111, 4'b0000, 4'b0000, 0, 4'b1010};
    tbl[7] = '{0, 0, 2'b00, 2'b00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, -1, 4'b0000};

    // Reset held with both requests high: nothing may be granted.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.op0 = 2'b10; bus.a0 = 4'b0110; bus.b0 = 4'b0011;
    bus.op1 = 2'b00; bus.a1 = 4'b1111; bus.b1 = 4'b0101;
    repeat (2) @(negedge clk);
    chk("rst.gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
    chk("rst.done", {30'd0, bus.done1, bus.done0}, 0);
    chk("rst.busy", {31'd0, bus.busy}, 0);
    chk("rst.result", {28'd0, bus.result}, 0);
    chk("rst.op_count", {24'd0, bus.op_count}, 0);
    $display("reset: gnt=%b%b busy=%b result=%b count=%0d",
             bus.gnt1, bus.gnt0, bus.busy, bus.result, bus.op_count);
    rst = 1'b0;
    run_round("rst_first", 0, 4'b0101);
    run_round("rst_second", 1, 4'b0101);

    for (int i = 0; i < 8; i++) begin
      bus.req0 = tbl[i].r0; bus.req1 = tbl[i].r1;
      bus.op0 = tbl[i].op0; bus.a0 = tbl[i].a0; bus.b0 = tbl[i].b0;
      bus.op1 = tbl[i].op1; bus.a1 = tbl[i].a1; bus.b1 = tbl[i].b1;
      run_round($sformatf("tbl%0d", i), tbl[i].win, tbl[i].res);
    end

    for (int i = 0; i < 200; i++) begin
      if (!bus.req0 && $urandom_range(0, 2) != 0) begin
        bus.req0 = 1'b1; bus.op0 = 2'($urandom); bus.a0 = W'($urandom); bus.b0 = W'($urandom);
      end
      if (!bus.req1 && $urandom_range(0, 2) != 0) begin
        bus.req1 = 1'b1; bus.op1 = 2'($urandom); bus.a1 = W'($urandom); bus.b1 = W'($urandom);
      end
      w  = model_win(bus.req0, bus.req1);
      er = (w == 0) ? ref_result(bus.op0, bus.a0, bus.b0) :
           (w == 1) ? ref_result(bus.op1, bus.a1, bus.b1) : '0;
      run_round($sformatf("rnd%0d", i), w, er);
    end

    // Reset asserted during EXEC: the in-flight operation must vanish.
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    bus.req0 = 1'b1; bus.op0 = 2'b01; bus.a0 = 4'b1111; bus.b0 = 4'b0000;
    @(negedge clk);
    chk("midrst.gnt0", {31'd0, bus.gnt0}, 1);
    bus.req0 = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst.async_gnt", {30'd0, bus.gnt1, bus.gnt0}, 0);
    chk("midrst.async_busy", {31'd0, bus.busy}, 0);
    chk("midrst.async_count", {24'd0, bus.op_count}, 0);
    @(negedge clk);
    rst = 1'b0;
    m_last = 1'b1; m_count = 8'd0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst.done", {30'd0, bus.done1, bus.done0}, 0);
      chk("midrst.result", {28'd0, bus.result}, 0);
      chk("midrst.op_count", {24'd0, bus.op_count}, 0);
      chk("midrst.busy", {31'd0, bus.busy}, 0);
    end
    $display("midrst: done=%b%b result=%b count=%0d",
             bus.done1, bus.done0, bus.result, bus.op_count);
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.op0 = 2'b10; bus.a0 = 4'b1010; bus.b0 = 4'b0110;
    run_round("post_rst_tie", 0, 4'b1100);
    bus.req1 = 1'b0;

    // 255 more operations bring the counter from 1 through 255 back to 0.
    for (int i = 0; i < 255; i++) begin
      bus.req0 = 1'b1; bus.op0 = 2'($urandom); bus.a0 = W'($urandom); bus.b0 = W'($urandom);
      run_round($sformatf("wrap%0d", i), 0, ref_result(bus.op0, bus.a0, bus.b0));
    end
    chk("wrap.op_count_zero", {24'd0, bus.op_count}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/logic_arbiter.md
# logic_arbiter

Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NOT) between two requesters. Arbitration is round-robin, and each operation is sequenced through a three-state FSM. Each requester gets a grant pulse when its operands are captured and a done pulse when its registered result is valid. The block sits in front of the BinaryLogic datapath and is the only path by which upstream logic reaches it.

## Interface
- WIDTH, 4, operand and result width in bits
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req0, req1  input  1  level request from requester 0 / 1
- op0, op1  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOT (~a, b ignored)
- a0, b0, a1, b1  input  WIDTH  operands per requester
- gnt0, gnt1  output  1  one-cycle pulse; operands of that requester captured
- done0, done1  output  1  one-cycle pulse; result valid for that requester
- result  output  WIDTH  registered result of last completed operation
- busy  output  1  high in EXEC and DONE states
- op_count  output  8  completed-operation counter, wraps 255->0

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - If neither req is high, stay in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not `last`.
  - On grant:
    - capture the winner's op, a, b into internal registers;
    - set `last` to the winner;
    - set the winner's gnt for the next cycle;
    - go to EXEC.
- EXEC:
  - result <= f(op, a, b) from captured registers; done of the granted requester <= 1; op_count <= op_count+1.
  - Go to DONE.
- DONE:
  - Clear done; go to IDLE. Requests are not sampled in DONE.
  - result holds until the next EXEC.
- `last` resets to 1, so requester 0 wins the first tie.
- Input changes after capture have no effect on the operation in flight.
- Requester protocol: deassert req in the cycle its gnt is high. Any req still high when IDLE is next sampled is a new request.
- gnt0 and gnt1 are never both high. done0 and done1 are never both high.
- All outputs are registered.
- Reset (async, any state):
  - state=IDLE, last=1;
  - gnt0=gnt1=done0=done1=busy=0;
  - result=0, op_count=0.
  - An in-flight operation is discarded; no done is issued for it.

## Timing
- Edge E0 samples req in IDLE.
- gnt is high during cycle E0–E1; busy rises after E0.
- Result and done are valid during cycle E1–E2.
- Back in IDLE after E2; the next grant is at E3 at the earliest.
- Grant-to-done latency: 1 cycle. Throughput: one operation per 3 cycles.
- Reset assertion clears outputs immediately, without waiting for a clock. Deassertion takes effect at the next rising edge.

## Test plan
1. Reset:
   - Stimulus: rst=1 for 2 cycles, with req0=req1=1.
   - Required: all outputs 0, no gnt. After release, the first grant goes to requester 0.
2. Single OR:
   - Stimulus: req0=1, op0=01, a0=1001, b0=0101.
   - Required: gnt0 pulse after E0. done0 and result=1101 after E1. op_count=1. busy low after E2.
3. Requester 1 OR:
   - Stimulus: req1=1, op1=01, a1=0011, b1=1100.
   - Required: gnt1, then done1 with result=1111. gnt0 and done0 stay 0.
4. Tie and round-robin:
   - Stimulus: both req held; op0=00, a0=1100, b0=1010; op1=10, a1=1100, b1=1010.
   - Required: gnt0 first with result=1000, then gnt1 with result=0110.
   - Stimulus: re-assert both.
   - Required: requester 0 wins again (last=1).
5. NOT and wrap:
   - Stimulus: op0=11, a0=0101, b0=1111.
   - Required: result=1010.
   - Stimulus: run 256 operations.
   - Required: op_count returns to 0.
6. Reset mid-operation:
   - Stimulus: assert rst during the EXEC cycle.
   - Required: done stays 0, result=0, op_count unchanged from reset value 0, state IDLE.
